// File: rtl/ifetch_rv32i_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack port plus the
// valid/ready instruction port toward decode.
// master = fetch unit; slave = memory model / decode stage.
interface ifetch_rv32i_if;
  // instruction memory side
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  // decode side
  logic        if_valid;
  logic        id_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [6:0]  if_opcode;
  logic [2:0]  if_funct3;
  logic [6:0]  if_funct7;
  logic [4:0]  if_rd;
  logic [4:0]  if_rs1;
  logic [4:0]  if_rs2;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output if_valid, if_pc, if_instr,
    output if_opcode, if_funct3, if_funct7, if_rd, if_rs1, if_rs2,
    input  id_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  if_valid, if_pc, if_instr,
    input  if_opcode, if_funct3, if_funct7, if_rd, if_rs1, if_rs2,
    output id_ready
  );
endinterface

// File: rtl/ifetch_rv32i.sv
// RV32I instruction fetch: PC, imem req/ack fetch, instruction register to decode.
// Latency: ack -> if_valid 1 cycle; first req 1 cycle after reset release.
// Backpressure: holds instruction and PC while id_ready=0; no new fetch until accepted.
//
// Ports: clock, reset_n (async active-low); bus (ifetch_rv32i_if.master:
// imem req/addr/ack/rdata, if_valid/id_ready, if_pc, if_instr and decode
// fields); redirect/redirect_pc from branch logic; fetch_err sticky timeout.
// Optional macro IFETCH_MISALIGN_CHK_EN: adds misalign_err and ignores
// redirects to non-word-aligned targets; otherwise the low two target bits
// are cleared.
module ifetch_rv32i #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  ifetch_rv32i_if.master        bus,
  input  logic                  redirect,
  input  logic [31:0]           redirect_pc,
  output logic                  fetch_err
`ifdef IFETCH_MISALIGN_CHK_EN
  ,
  output logic                  misalign_err
`endif
);

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [7:0]  TMO_MAX = 8'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, FETCH, DROP, VALID} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] drop_addr, drop_addr_n;
  logic [31:0] instr_q, pc_q;
  logic        capture;
  logic [7:0]  tmo_cnt, tmo_cnt_n;
  logic        waiting;
  logic        redir_ok;
  logic [31:0] redir_tgt;

`ifdef IFETCH_MISALIGN_CHK_EN
  logic misalign;
  // A misaligned target is flagged and otherwise behaves as no redirect.
  assign misalign  = redirect && (redirect_pc[1:0] != 2'b00);
  assign redir_ok  = redirect && !misalign;
  assign redir_tgt = redirect_pc;
`else
  assign redir_ok  = redirect;
  assign redir_tgt = redirect_pc & 32'hFFFF_FFFC;
`endif

  // An outstanding request cannot be withdrawn, so a redirect during a
  // pending fetch parks in DROP with the old address still on the bus.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    drop_addr_n = drop_addr;
    capture     = 1'b0;
    case (state)
      IDLE: begin
        state_n = FETCH;
        if (redir_ok) pc_n = redir_tgt;
      end
      FETCH: begin
        if (redir_ok) begin
          pc_n = redir_tgt;
          if (!bus.imem_ack) begin
            state_n     = DROP;
            drop_addr_n = pc;
          end
        end else if (bus.imem_ack) begin
          capture = 1'b1;
          state_n = VALID;
        end
      end
      DROP: begin
        if (redir_ok)     pc_n    = redir_tgt;
        if (bus.imem_ack) state_n = FETCH;
      end
      VALID: begin
        if (redir_ok) begin
          pc_n    = redir_tgt;
          state_n = FETCH;
        end else if (bus.id_ready) begin
          pc_n    = pc + 32'd4;
          state_n = FETCH;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Every exit from FETCH/DROP needs an ack, so clearing on "not waiting"
  // covers both the ack and the leave-state conditions.
  assign waiting   = ((state == FETCH) || (state == DROP)) && !bus.imem_ack;
  assign tmo_cnt_n = !waiting ? 8'd0 :
                     (tmo_cnt == TMO_MAX) ? tmo_cnt : tmo_cnt + 8'd1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      drop_addr <= RESET_PC;
      instr_q   <= NOP;
      pc_q      <= RESET_PC;
      tmo_cnt   <= 8'd0;
      fetch_err <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      drop_addr <= drop_addr_n;
      tmo_cnt   <= tmo_cnt_n;
      if (capture) begin
        instr_q <= bus.imem_rdata;
        pc_q    <= pc;
      end
      if (waiting && (tmo_cnt_n == TMO_MAX)) fetch_err <= 1'b1;
    end
  end

`ifdef IFETCH_MISALIGN_CHK_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) misalign_err <= 1'b0;
    else          misalign_err <= misalign;
  end
`endif

  assign bus.imem_req  = (state == FETCH) || (state == DROP);
  assign bus.imem_addr = (state == DROP) ? drop_addr : pc;
  assign bus.if_valid  = (state == VALID);
  assign bus.if_pc     = pc_q;
  assign bus.if_instr  = instr_q;
  assign bus.if_opcode = instr_q[6:0];
  assign bus.if_rd     = instr_q[11:7];
  assign bus.if_funct3 = instr_q[14:12];
  assign bus.if_rs1    = instr_q[19:15];
  assign bus.if_rs2    = instr_q[24:20];
  assign bus.if_funct7 = instr_q[31:25];

endmodule

// File: tb/tb_ifetch_rv32i.sv
// Bench for ifetch_rv32i: memory model driven from the main thread, expected
// (pc, instr) pairs queued at each accepted ack and checked when if_valid rises.
module tb_ifetch_rv32i;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam int          TIMEOUT_CYC = 16;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_err;
`ifdef IFETCH_MISALIGN_CHK_EN
  logic        misalign_err;
`endif

  ifetch_rv32i_if bus();

  ifetch_rv32i #(.RESET_PC(RESET_PC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_err   (fetch_err)
`ifdef IFETCH_MISALIGN_CHK_EN
    ,
    .misalign_err(misalign_err)
`endif
  );

  always #5 clock = ~clock;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h0050_0093;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard side: compare each new instruction against the queue head.
  logic prev_valid = 1'b0;
  exp_t mon_e;
  always @(negedge clock) begin
    if (bus.if_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_pc",     bus.if_pc,     mon_e.pc);
        chk("sb_instr",  bus.if_instr,  mon_e.instr);
        chk("sb_opcode", bus.if_opcode, mon_e.instr[6:0]);
        chk("sb_rd",     bus.if_rd,     mon_e.instr[11:7]);
        chk("sb_funct3", bus.if_funct3, mon_e.instr[14:12]);
        chk("sb_rs1",    bus.if_rs1,    mon_e.instr[19:15]);
        chk("sb_rs2",    bus.if_rs2,    mon_e.instr[24:20]);
        chk("sb_funct7", bus.if_funct7, mon_e.instr[31:25]);
      end
    end
    prev_valid = bus.if_valid;
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic wait_req();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.imem_req) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("req_seen", ok, 1);
  endtask

  // Ack after 'delay' waiting cycles, queueing the expected instruction.
  task automatic serve(input int delay, input logic [31:0] exp_addr);
    wait_req();
    for (int i = 0; i < delay; i++) begin
      chk("wait_addr", bus.imem_addr, exp_addr);
      chk("wait_valid", bus.if_valid, 0);
      tick();
    end
    chk("req_addr", bus.imem_addr, exp_addr);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = mem_word(exp_addr);
    exp_q.push_back('{pc: exp_addr, instr: mem_word(exp_addr)});
    tick();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'hDEAD_BEEF;
    chk("valid_after_ack", bus.if_valid, 1);
  endtask

  task automatic pulse_ready();
    bus.id_ready = 1'b1;
    tick();
    bus.id_ready = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] tgt, input logic with_ready);
    redirect     = 1'b1;
    redirect_pc  = tgt;
    bus.id_ready = with_ready;
    tick();
    redirect     = 1'b0;
    bus.id_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    logic [31:0] t5_addr;
    reset_n        = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = 32'h0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'hDEAD_BEEF;
    bus.id_ready   = 1'b0;
    tick();
    tick();
    chk("rst_req",   bus.imem_req, 0);
    chk("rst_valid", bus.if_valid, 0);
    chk("rst_err",   fetch_err,    0);
    chk("rst_instr", bus.if_instr, 32'h0000_0013);
    chk("rst_pc",    bus.if_pc,    RESET_PC);

    // 1: first fetch, same-cycle ack
    reset_n = 1'b1;
    chk("t1_req_idle", bus.imem_req, 0);
    tick();
    chk("t1_req_rise", bus.imem_req, 1);
    serve(0, 32'h0);
    chk("t1_pc",     bus.if_pc,     32'h0);
    chk("t1_opcode", bus.if_opcode, 32'h13);
    chk("t1_rd",     bus.if_rd,     32'd1);
    chk("t1_rs1",    bus.if_rs1,    32'd0);
    chk("t1_funct3", bus.if_funct3, 32'd0);

    // 2: backpressure hold, then fetch at 4 with 3-cycle ack delay
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_valid", bus.if_valid, 1);
      chk("t2_hold_instr", bus.if_instr, 32'h0050_0093);
      chk("t2_hold_req",   bus.imem_req, 0);
    end
    pulse_ready();
    chk("t2_next_addr", bus.imem_addr, 32'h4);
    chk("t2_valid_low", bus.if_valid,  0);
    serve(3, 32'h4);

    // 3: redirect during pending fetch goes through DROP
    pulse_ready();
    chk("t3_addr", bus.imem_addr, 32'h8);
    redirect_to(32'h100, 1'b0);
    chk("t3_drop_req",  bus.imem_req,  1);
    chk("t3_drop_addr", bus.imem_addr, 32'h8);
    tick();
    chk("t3_drop_addr2", bus.imem_addr, 32'h8);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.imem_ack = 1'b0;
    chk("t3_discard_valid", bus.if_valid,  0);
    chk("t3_new_addr",      bus.imem_addr, 32'h100);
    serve(0, 32'h100);
    chk("t3_if_pc", bus.if_pc, 32'h100);

    // 4: redirect beats id_ready in VALID
    redirect_to(32'h40, 1'b1);
    chk("t4_valid_low", bus.if_valid,  0);
    chk("t4_addr",      bus.imem_addr, 32'h40);
    serve(1, 32'h40);

    // 6: PC wraps past the top of the address space
    redirect_to(32'hFFFF_FFFC, 1'b0);
    chk("t6_top_addr", bus.imem_addr, 32'hFFFF_FFFC);
    serve(0, 32'hFFFF_FFFC);
    pulse_ready();
    chk("t6_wrap_addr", bus.imem_addr, 32'h0);
    serve(0, 32'h0);

    redirect_to(32'h102, 1'b0);
`ifdef IFETCH_MISALIGN_CHK_EN
    chk("t6_mis_err",   misalign_err, 1);
    chk("t6_mis_valid", bus.if_valid, 1);
    chk("t6_mis_pc",    bus.if_pc,    32'h0);
    tick();
    chk("t6_mis_pulse", misalign_err, 0);
    pulse_ready();
    chk("t6_mis_next", bus.imem_addr, 32'h4);
    serve(0, 32'h4);
    t5_addr = 32'h8;
`else
    chk("t6_align_valid", bus.if_valid,  0);
    chk("t6_align_addr",  bus.imem_addr, 32'h100);
    serve(0, 32'h100);
    t5_addr = 32'h104;
`endif

    // 5: fetch timeout, sticky error, async reset
    pulse_ready();
    chk("t5_addr",      bus.imem_addr, t5_addr);
    chk("t5_err_start", fetch_err,     0);
    for (int i = 0; i < TIMEOUT_CYC - 1; i++) tick();
    chk("t5_err_before", fetch_err, 0);
    tick();
    chk("t5_err_set", fetch_err, 1);
    for (int i = 0; i < 4; i++) tick();
    chk("t5_err_hold", fetch_err, 1);
    serve(0, t5_addr);
    chk("t5_err_sticky", fetch_err, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_arst_req",   bus.imem_req, 0);
    chk("t5_arst_valid", bus.if_valid, 0);
    chk("t5_arst_err",   fetch_err,    0);
    chk("t5_arst_instr", bus.if_instr, 32'h0000_0013);
    chk("t5_arst_pc",    bus.if_pc,    RESET_PC);
`ifdef IFETCH_MISALIGN_CHK_EN
    chk("t5_arst_mis",   misalign_err, 0);
`endif
    tick();
    chk("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/ifetch_rv32i.md
Name: ifetch_rv32i

Overview:
Instruction fetch stage directly upstream of the RV32I control unit. It holds the PC and fetches instruction words from instruction memory over a req/ack handshake. Each captured word is held in an instruction register, and its decode fields (opcode, funct3, funct7, rd, rs1, rs2) are presented to the decode/control stage under a valid/ready handshake. A redirect input from the branch/jump logic replaces the PC and flushes any fetch in progress.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
TIMEOUT_CYC, 16, number of cycles req may wait for ack before fetch_err sets (range 2..255).

Ports:
clock  in  1  system clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
imem_req  out  1  fetch request to instruction memory.
imem_addr  out  32  fetch address; stable while imem_req=1 and no ack yet.
imem_ack  in  1  memory returns imem_rdata this cycle; may assert in the same cycle as req.
imem_rdata  in  32  instruction word, valid when imem_ack=1.
redirect  in  1  load redirect_pc as the new PC (taken branch, JAL, JALR).
redirect_pc  in  32  redirect target.
id_ready  in  1  decode stage accepts the current instruction.
if_valid  out  1  instruction register holds a valid instruction.
if_pc  out  32  PC of the instruction in the instruction register.
if_instr  out  32  instruction register.
if_opcode  out  7  if_instr[6:0].
if_funct3  out  3  if_instr[14:12].
if_funct7  out  7  if_instr[31:25].
if_rd  out  5  if_instr[11:7].
if_rs1  out  5  if_instr[19:15].
if_rs2  out  5  if_instr[24:20].
fetch_err  out  1  sticky flag: fetch timeout occurred.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE, pc=RESET_PC, if_instr=32'h0000_0013 (NOP), if_pc=RESET_PC.
  - if_valid=0, imem_req=0, fetch_err=0, timeout counter=0.
- States: IDLE, FETCH, DROP, VALID.
- IDLE: always moves to FETCH on the next edge. imem_req first asserts 1 cycle after reset is released.
- FETCH: imem_req=1, imem_addr=pc.
  - On imem_ack: if_instr<=imem_rdata, if_pc<=pc, go to VALID.
  - Minimum latency from req to if_valid is 1 cycle.
- VALID: if_valid=1, imem_req=0.
  - On id_ready: pc<=pc+4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0), go to FETCH.
  - Without id_ready, all outputs hold.
- Redirect has the highest priority in every state:
  - IDLE or VALID: pc<=redirect_pc, go to FETCH, if_valid=0 the next cycle. redirect together with id_ready in VALID uses redirect_pc, never pc+4.
  - FETCH with imem_ack in the same cycle: the returned data is discarded, pc<=redirect_pc, go to FETCH.
  - FETCH without imem_ack: a request cannot be aborted. pc<=redirect_pc and go to DROP; imem_req stays 1 and imem_addr stays at the old address.
  - DROP: on imem_ack the data is discarded and the next state is FETCH at the new pc. A further redirect while in DROP updates pc only.
- if_valid is 0 in IDLE, FETCH and DROP.
- Timeout:
  - The counter increments each cycle in FETCH or DROP with imem_req=1 and imem_ack=0, and clears on ack or on leaving those states.
  - When the count reaches TIMEOUT_CYC, fetch_err<=1. fetch_err is sticky until reset.
  - The fetch keeps waiting; the counter saturates.
- Decode-field outputs are pure slices of if_instr; there is no extra latency.
- Internal pc is not an output. imem_addr=pc in FETCH and the held old address in DROP.

Optional Feature:
IFETCH_MISALIGN_CHK_EN:
- Defined:
  - Adds output misalign_err (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=0 sets misalign_err for exactly 1 cycle (the cycle after the redirect).
  - That redirect is ignored: pc and state behave as if redirect=0.
- Undefined:
  - No misalign_err port.
  - redirect_pc[1:0] are forced to 0 when loaded into pc.

Test Plan:
1. Release reset with RESET_PC=0 and memory acking the same cycle with 32'h00500093 -> imem_req rises 1 cycle after release, then if_valid=1, if_pc=0, if_opcode=7'h13, if_rd=1, if_rs1=0, if_funct3=0.
2. Hold id_ready=0 for 5 cycles in VALID, then pulse it -> outputs stable; the next imem_addr=4; a 3-cycle ack delay makes if_valid rise 3 cycles later.
3. Redirect to 32'h100 while in FETCH with ack delayed 2 cycles -> DROP keeps imem_addr at the old address until ack; the old data is discarded; the next req goes to 32'h100 and if_pc=32'h100.
4. In VALID, assert redirect=1 (redirect_pc=32'h40) together with id_ready=1 -> the next fetch is at 32'h40, not pc+4, and if_valid=0 the next cycle.
5. Never ack with TIMEOUT_CYC=16 -> fetch_err=1 after 16 waiting cycles, stays 1 after a later ack, and clears only on reset_n=0 (asserted asynchronously mid-cycle clears all outputs immediately).
6. pc=32'hFFFF_FFFC with id_ready -> the next imem_addr=0. With IFETCH_MISALIGN_CHK_EN defined, a redirect to 32'h102 gives a 1-cycle misalign_err and the PC is unchanged.
